trail_ctrl: RTL and testbench
=============================

# trail_ctrl

Assignment-trail controller for the SAT core. It owns a `stack` instance that holds every variable assignment in chronological order and tracks the current decision level. On a conflict it sequences non-chronological backtrack: it pops entries and streams each undone assignment to the variable-state table until the requested level is reached. It sits between the decision/propagation units, which push, and the conflict analyser, which requests backtracks.

## Interface
- `VAR_W`, 16: variable-id width.
- `DEPTH`, 64: trail capacity in entries.
- `LVL_W`, 8: decision-level width.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush of trail and level.
- `assign_valid`  in  1  push request.
- `assign_ready`  out  1  push accepted when high with valid.
- `assign_var`  in  VAR_W  variable id.
- `assign_val`  in  1  assigned polarity.
- `assign_is_dec`  in  1  entry is a decision (opens a new level).
- `bt_valid`  in  1  backtrack request.
- `bt_ready`  out  1  backtrack accepted.
- `bt_level`  in  LVL_W  target level.
- `undo_valid`  out  1  undone entry presented.
- `undo_ready`  in  1  consumer accepts undone entry.
- `undo_var`  out  VAR_W  undone variable.
- `undo_val`  out  1  its polarity.
- `bt_done`  out  1  one-cycle pulse when the backtrack completes.
- `cur_level`  out  LVL_W  current decision level.
- `trail_count`  out  $clog2(DEPTH)+1  occupancy.
- `bt_error`  out  1  sticky: trail emptied during a backtrack.
- `stat_bt_cnt`, `stat_undo_cnt`  out  32  statistics (see Configuration).

## Operation
- States: IDLE, POP, DONE.
- Stack entry is {var, val, is_dec}, width VAR_W+2.
- **IDLE**
  - `assign_ready = !full && !bt_valid && !(assign_is_dec && cur_level == max)`.
  - An accepted push writes the entry. If is_dec, `cur_level` increments.
  - `bt_ready` = 1.
  - An accepted backtrack with `bt_level >= cur_level` goes to DONE with no pops. Otherwise the target is latched and the state goes to POP.
  - When `bt_valid` and `assign_valid` are both high, the backtrack wins and the push stalls.
- **POP**
  - `undo_valid` = 1, with `undo_var`/`undo_val` taken from the stack top.
  - Each undo handshake pops one entry. A popped decision decrements `cur_level`.
  - When the decremented level equals the target, go to DONE.
  - If the stack becomes empty before the target is reached, set `bt_error` and go to DONE.
  - `assign_ready` = 0 and `bt_ready` = 0.
- **DONE**
  - `bt_done` = 1 for this cycle only; return to IDLE.
- **clear**
  - Highest priority in every state.
  - Clears the stack, sets `cur_level` = 0, returns to IDLE, and clears `bt_error`.
  - No `bt_done` is produced for an aborted backtrack.
- **Reset values:** state IDLE, `cur_level` 0, `trail_count` 0, `bt_error` 0, all valid/ready/done outputs 0 while `rst` is high. Statistics counters are 0.
- Level-0 entries (implications before the first decision) are never popped by a legal backtrack.

## Timing
- Backtrack accepted at edge N: `undo_valid` is high in the cycle after N.
- Throughput is one undo per cycle while `undo_ready` is held high.
- `bt_done` is asserted the cycle after the final pop handshake.
- For a zero-pop backtrack, `bt_done` is asserted the cycle after acceptance.
- Push latency: `trail_count` and `cur_level` update at the accepting edge.
- `undo_*` holds stable while `undo_valid && !undo_ready`.

## Configuration
- `TRAIL_STATS_EN`
  - **Defined:** `stat_bt_cnt` increments on each accepted backtrack. `stat_undo_cnt` increments on each undo handshake. Both saturate at all-ones and are cleared by `rst` and `clear`.
  - **Undefined:** both outputs are tied to 0 and no counter logic is built.

## Structure
- Package `trail_pkg`:
  - `trail_entry_t` packed struct.
  - `trail_state_e` enum.
  - Width helper constants derived from `VAR_W`/`LVL_W`.
- Sub-module: the existing utils `stack`, instantiated with `WIDTH = VAR_W+2` and `DEPTH`.
  - Its active-low reset is driven by `~rst`.
  - Its `clear` input is driven from `clear`.
- All sequencing lives in `trail_ctrl`.

## Test plan
- Push x1 (dec), x2, x3 (dec), x4 → `cur_level` = 2, `trail_count` = 4.
- Backtrack to level 1 → undo stream x4, x3; `cur_level` = 1; `bt_done` pulses once; `trail_count` = 2.
- Backtrack with `bt_level` = 5 when `cur_level` = 1 → zero undos; `bt_done` the next cycle.
- Fill to `DEPTH`; next push sees `assign_ready` = 0; a backtrack to 0 then drains all entries above level 0.
- Hold `undo_ready` = 0 for 3 cycles mid-backtrack → `undo_*` stable and no pop occurs.
- `clear` asserted mid-POP → next cycle IDLE, `trail_count` = 0, no `bt_done`.
- With `TRAIL_STATS_EN`, after the level-1 backtrack: `stat_bt_cnt` = 1, `stat_undo_cnt` = 2.

Source files
------------

// File: rtl/trail_pkg.sv
// Shared types and width helpers for the assignment-trail controller.
package trail_pkg;

  localparam int TRAIL_VAR_W   = 16;
  localparam int TRAIL_LVL_W   = 8;
  localparam int TRAIL_ENTRY_W = TRAIL_VAR_W + 2;

  // Field order matches the packed stack word {var, val, is_dec}.
  typedef struct packed {
    logic [TRAIL_VAR_W-1:0] var_id;
    logic                   val;
    logic                   is_dec;
  } trail_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DONE
  } trail_state_e;

  function automatic int entry_width(input int var_w);
    return var_w + 2;
  endfunction

endpackage

// File: rtl/trail_ctrl_stack.sv
// LIFO used as the assignment trail; data storage is not reset, only occupancy.
module stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       top_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    top_idx;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (AW+1)'(DEPTH));
    do_push = push && !full && !clear;
    do_pop  = pop && !empty && !push && !clear;
    top_idx = AW'(count_q - (AW+1)'(1));
    count_d = count_q;
    if (clear)        count_d = '0;
    else if (do_push) count_d = count_q + (AW+1)'(1);
    else if (do_pop)  count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[count_q[AW-1:0]] <= push_data;
  end

  assign top_data = mem_q[top_idx];
  assign count    = count_q;

endmodule

// File: rtl/trail_ctrl.sv
// Assignment-trail controller: push trail entries, sequence backtracks by popping to a level.
// Optional statistics counters are built when TRAIL_STATS_EN is defined.
module trail_ctrl
  import trail_pkg::*;
#(
  parameter int VAR_W = TRAIL_VAR_W,
  parameter int DEPTH = 64,
  parameter int LVL_W = TRAIL_LVL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   assign_valid,
  output logic                   assign_ready,
  input  logic [VAR_W-1:0]       assign_var,
  input  logic                   assign_val,
  input  logic                   assign_is_dec,
  input  logic                   bt_valid,
  output logic                   bt_ready,
  input  logic [LVL_W-1:0]       bt_level,
  output logic                   undo_valid,
  input  logic                   undo_ready,
  output logic [VAR_W-1:0]       undo_var,
  output logic                   undo_val,
  output logic                   bt_done,
  output logic [LVL_W-1:0]       cur_level,
  output logic [$clog2(DEPTH):0] trail_count,
  output logic                   bt_error,
  output logic [31:0]            stat_bt_cnt,
  output logic [31:0]            stat_undo_cnt
);

  localparam int ENTRY_W = entry_width(VAR_W);
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] LVL_MAX = '1;

  trail_state_e     state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d, target_q, target_d;
  logic             err_q, err_d;

  logic               stk_push, stk_pop, stk_empty, stk_full;
  logic [ENTRY_W-1:0] stk_top, push_entry;
  logic [CW-1:0]      stk_count;
  logic               push_acc, bt_acc;

  assign push_entry = {assign_var, assign_val, assign_is_dec};

  stack #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (~rst),
    .clear     (clear),
    .push      (stk_push),
    .push_data (push_entry),
    .pop       (stk_pop),
    .top_data  (stk_top),
    .count     (stk_count),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    target_d     = target_q;
    err_d        = err_q;
    assign_ready = 1'b0;
    bt_ready     = 1'b0;
    undo_valid   = 1'b0;
    bt_done      = 1'b0;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    push_acc     = 1'b0;
    bt_acc       = 1'b0;
    case (state_q)
      IDLE: begin
        // A pending backtrack always stalls pushes so the trail is frozen for it.
        bt_ready     = !rst && !clear;
        assign_ready = !rst && !clear && !stk_full && !bt_valid &&
                       !(assign_is_dec && level_q == LVL_MAX);
        bt_acc   = bt_valid && bt_ready;
        push_acc = assign_valid && assign_ready;
        stk_push = push_acc;
        if (push_acc && assign_is_dec) level_d = level_q + LVL_W'(1);
        if (bt_acc) begin
          if (bt_level >= level_q) begin
            state_d = DONE;
          end else begin
            target_d = bt_level;
            state_d  = POP;
          end
        end
      end
      POP: begin
        if (stk_empty) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          undo_valid = 1'b1;
          if (undo_ready && !clear) begin
            stk_pop = 1'b1;
            if (stk_top[0]) begin
              level_d = level_q - LVL_W'(1);
              if ((level_q - LVL_W'(1)) == target_q) state_d = DONE;
            end
            // Last entry gone without reaching the target level.
            if (stk_count == CW'(1) && state_d != DONE) begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        bt_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      level_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      level_q  <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      err_q    <= err_d;
    end
  end

  assign undo_var    = stk_top[ENTRY_W-1:2];
  assign undo_val    = stk_top[1];
  assign cur_level   = level_q;
  assign trail_count = stk_count;
  assign bt_error    = err_q;

`ifdef TRAIL_STATS_EN
  logic [31:0] stat_bt_q, stat_bt_d, stat_undo_q, stat_undo_d;

  always_comb begin
    stat_bt_d   = stat_bt_q;
    stat_undo_d = stat_undo_q;
    if (bt_acc && stat_bt_q != '1)    stat_bt_d   = stat_bt_q + 32'd1;
    if (stk_pop && stat_undo_q != '1) stat_undo_d = stat_undo_q + 32'd1;
    if (clear) begin
      stat_bt_d   = '0;
      stat_undo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bt_q   <= '0;
      stat_undo_q <= '0;
    end else begin
      stat_bt_q   <= stat_bt_d;
      stat_undo_q <= stat_undo_d;
    end
  end

  assign stat_bt_cnt   = stat_bt_q;
  assign stat_undo_cnt = stat_undo_q;
`else
  assign stat_bt_cnt   = '0;
  assign stat_undo_cnt = '0;
`endif

endmodule

// File: tb/tb_trail_ctrl.sv
// Self-checking bench for trail_ctrl against a queue-based trail model.
module tb_trail_ctrl;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        assign_valid, assign_ready, assign_val, assign_is_dec;
  logic [15:0] assign_var;
  logic        bt_valid, bt_ready;
  logic [7:0]  bt_level;
  logic        undo_valid, undo_ready, undo_val;
  logic [15:0] undo_var;
  logic        bt_done, bt_error;
  logic [7:0]  cur_level;
  logic [6:0]  trail_count;
  logic [31:0] stat_bt_cnt, stat_undo_cnt;

  int total = 0;
  int bad   = 0;

  logic [17:0] mq[$];
  logic [17:0] exp_q[$];
  logic [16:0] got_q[$];
  int          mbt   = 0;
  int          mundo = 0;

  always #5 clk = ~clk;

  trail_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .assign_valid  (assign_valid),
    .assign_ready  (assign_ready),
    .assign_var    (assign_var),
    .assign_val    (assign_val),
    .assign_is_dec (assign_is_dec),
    .bt_valid      (bt_valid),
    .bt_ready      (bt_ready),
    .bt_level      (bt_level),
    .undo_valid    (undo_valid),
    .undo_ready    (undo_ready),
    .undo_var      (undo_var),
    .undo_val      (undo_val),
    .bt_done       (bt_done),
    .cur_level     (cur_level),
    .trail_count   (trail_count),
    .bt_error      (bt_error),
    .stat_bt_cnt   (stat_bt_cnt),
    .stat_undo_cnt (stat_undo_cnt)
  );

  function automatic int mlevel();
    int n = 0;
    foreach (mq[i]) if (mq[i][0]) n++;
    return n;
  endfunction

  // Undo everything above the target level, newest first.
  task automatic model_bt(input int lvl);
    exp_q.delete();
    while (mlevel() > lvl) exp_q.push_back(mq.pop_back());
  endtask

  task automatic do_push(input logic [15:0] v, input logic val, input logic dec, output bit ok);
    ok = 0;
    assign_var = v; assign_val = val; assign_is_dec = dec; assign_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (assign_ready) ok = 1;
      @(posedge clk); #1;
    end
    assign_valid = 1'b0;
    if (ok) mq.push_back({v, val, dec});
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mq.delete(); mbt = 0; mundo = 0;
  endtask

  task automatic run_bt(input logic [7:0] lvl, input int stall, input bit rnd,
                        output bit acc, output int done_cnt, output int done_at, output bit stall_ok);
    logic [15:0] sv;
    logic [6:0]  sc;
    got_q.delete();
    acc = 0; done_cnt = 0; done_at = -1; stall_ok = 1;
    bt_level = lvl; bt_valid = 1'b1;
    @(negedge clk);
    acc = bt_ready;
    @(posedge clk); #1;
    bt_valid = 1'b0;
    if (!acc) return;
    mbt++;
    for (int c = 1; c <= 300; c++) begin
      undo_ready = (c <= stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      if (c <= stall) begin
        if (c == 1) begin sv = undo_var; sc = trail_count; end
        if (!undo_valid || undo_var !== sv || trail_count !== sc) stall_ok = 0;
      end
      if (bt_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end else if (undo_valid && undo_ready) begin
        got_q.push_back({undo_var, undo_val});
      end
      @(posedge clk); #1;
      if (done_at > 0 && c > done_at) break;
    end
    undo_ready = 1'b0;
    mundo += got_q.size();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    assign_valid = 1'b1; assign_var = 16'h1; assign_val = 1'b0; assign_is_dec = 1'b0;
    bt_valid = 1'b0; bt_level = '0; undo_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({assign_ready, bt_ready, undo_valid, bt_done, bt_error} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 00000", {assign_ready, bt_ready, undo_valid, bt_done, bt_error});
    end
    total++;
    if (cur_level !== 8'd0 || trail_count !== 7'd0) begin
      bad++; $display("FAIL reset_cnt: got lvl=%0d cnt=%0d want 0 0", cur_level, trail_count);
    end
    total++;
    if (stat_bt_cnt !== 32'd0 || stat_undo_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_stats: got %0d %0d want 0 0", stat_bt_cnt, stat_undo_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0; assign_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bt_ready !== 1'b1) begin
      bad++; $display("FAIL reset_idle: got bt_ready=%b want 1", bt_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_push_bt();
    bit ok, acc, sok;
    int dc, da, m, fails;
    fails = 0;
    do_push(16'd1, 1'b1, 1'b1, ok); if (!ok) fails++;
    do_push(16'd2, 1'b0, 1'b0, ok); if (!ok) fails++;
    do_push(16'd3, 1'b1, 1'b1, ok); if (!ok) fails++;
    do_push(16'd4, 1'b0, 1'b0, ok); if (!ok) fails++;
    total++;
    if (fails != 0) begin bad++; $display("FAIL push_accept: got %0d refused want 0", fails); end
    total++;
    if (cur_level !== 8'd2 || trail_count !== 7'd4) begin
      bad++; $display("FAIL push_counts: got lvl=%0d cnt=%0d want 2 4", cur_level, trail_count);
    end
    model_bt(1);
    run_bt(8'd1, 0, 0, acc, dc, da, sok);
    m = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i][17:1]) m++;
    total++;
    if (!acc || got_q.size() != 2 || exp_q.size() != 2 || m != 0) begin
      bad++; $display("FAIL bt1_stream: got acc=%0d n=%0d mism=%0d want 1 2 0", acc, got_q.size(), m);
    end
    total++;
    if (dc != 1 || da != 3) begin
      bad++; $display("FAIL bt1_done: got pulses=%0d at=%0d want 1 3", dc, da);
    end
    total++;
    if (cur_level !== 8'd1 || trail_count !== 7'd2 || bt_error !== 1'b0) begin
      bad++; $display("FAIL bt1_after: got lvl=%0d cnt=%0d err=%b want 1 2 0", cur_level, trail_count, bt_error);
    end
    total++;
`ifdef TRAIL_STATS_EN
    if (stat_bt_cnt !== 32'(mbt) || stat_undo_cnt !== 32'(mundo) || mbt != 1 || mundo != 2) begin
      bad++; $display("FAIL bt1_stats: got %0d %0d want 1 2", stat_bt_cnt, stat_undo_cnt);
    end
`else
    if (stat_bt_cnt !== 32'd0 || stat_undo_cnt !== 32'd0) begin
      bad++; $display("FAIL bt1_stats: got %0d %0d want 0 0", stat_bt_cnt, stat_undo_cnt);
    end
`endif
  endtask

  task automatic test_zero_pop();
    bit acc, sok;
    int dc, da;
    model_bt(5);
    run_bt(8'd5, 0, 0, acc, dc, da, sok);
    total++;
    if (!acc || got_q.size() != 0 || exp_q.size() != 0) begin
      bad++; $display("FAIL zero_stream: got acc=%0d n=%0d want 1 0", acc, got_q.size());
    end
    total++;
    if (dc != 1 || da != 1) begin
      bad++; $display("FAIL zero_done: got pulses=%0d at=%0d want 1 1", dc, da);
    end
    total++;
    if (cur_level !== 8'(mlevel()) || trail_count !== 7'(mq.size())) begin
      bad++; $display("FAIL zero_after: got lvl=%0d cnt=%0d want %0d %0d", cur_level, trail_count, mlevel(), mq.size());
    end
  endtask

  task automatic test_priority();
    int c0;
    c0 = mq.size();
    assign_valid = 1'b1; assign_var = 16'h55; assign_val = 1'b1; assign_is_dec = 1'b0;
    bt_valid = 1'b1; bt_level = 8'd200;
    @(negedge clk);
    total++;
    if (assign_ready !== 1'b0 || bt_ready !== 1'b1) begin
      bad++; $display("FAIL prio_ready: got a=%b b=%b want 0 1", assign_ready, bt_ready);
    end
    @(posedge clk); #1;
    bt_valid = 1'b0; mbt++;
    @(negedge clk);
    total++;
    if (bt_done !== 1'b1 || assign_ready !== 1'b0 || trail_count !== 7'(c0)) begin
      bad++; $display("FAIL prio_done: got done=%b a=%b cnt=%0d want 1 0 %0d", bt_done, assign_ready, trail_count, c0);
    end
    @(posedge clk); #1;
    assign_valid = 1'b0;
  endtask

  task automatic test_stall();
    bit ok, acc, sok;
    int dc, da, m;
    do_push(16'hA, 1'b1, 1'b1, ok);
    do_push(16'hB, 1'b0, 1'b0, ok);
    do_push(16'hC, 1'b1, 1'b1, ok);
    model_bt(1);
    run_bt(8'd1, 3, 0, acc, dc, da, sok);
    total++;
    if (!sok) begin bad++; $display("FAIL stall_stable: got changed=1 want 0"); end
    m = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i][17:1]) m++;
    total++;
    if (!acc || got_q.size() != exp_q.size() || m != 0 || exp_q.size() != 3) begin
      bad++; $display("FAIL stall_stream: got n=%0d mism=%0d want %0d 0", got_q.size(), m, exp_q.size());
    end
    total++;
    if (dc != 1 || da != 7) begin
      bad++; $display("FAIL stall_done: got pulses=%0d at=%0d want 1 7", dc, da);
    end
  endtask

  task automatic test_clear_mid_pop();
    bit ok;
    int seen;
    do_push(16'h10, 1'b0, 1'b1, ok);
    do_push(16'h11, 1'b1, 1'b0, ok);
    do_push(16'h12, 1'b0, 1'b1, ok);
    do_push(16'h13, 1'b1, 1'b1, ok);
    bt_level = 8'd0; bt_valid = 1'b1;
    @(posedge clk); #1;
    bt_valid = 1'b0; undo_ready = 1'b1;
    @(posedge clk); #1;
    undo_ready = 1'b0;
    pulse_clear();
    @(negedge clk);
    total++;
    if (trail_count !== 7'd0 || cur_level !== 8'd0 || undo_valid !== 1'b0 || bt_ready !== 1'b1) begin
      bad++; $display("FAIL clear_state: got cnt=%0d lvl=%0d uv=%b br=%b want 0 0 0 1", trail_count, cur_level, undo_valid, bt_ready);
    end
    seen = bt_done;
    @(posedge clk); #1;
    @(negedge clk);
    seen += bt_done;
    total++;
    if (seen != 0) begin bad++; $display("FAIL clear_nodone: got pulses=%0d want 0", seen); end
    total++;
    if (stat_bt_cnt !== 32'd0 || stat_undo_cnt !== 32'd0) begin
      bad++; $display("FAIL clear_stats: got %0d %0d want 0 0", stat_bt_cnt, stat_undo_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_drain();
    bit ok, acc, sok;
    int fails, dc, da, m;
    fails = 0;
    for (int i = 0; i < 64; i++) begin
      do_push(16'($urandom), 1'($urandom), (i == 3) || (i > 3 && $urandom_range(0, 3) == 0), ok);
      if (!ok) fails++;
    end
    total++;
    if (fails != 0 || trail_count !== 7'd64) begin
      bad++; $display("FAIL full_fill: got refused=%0d cnt=%0d want 0 64", fails, trail_count);
    end
    assign_valid = 1'b1; assign_is_dec = 1'b0;
    @(negedge clk);
    total++;
    if (assign_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", assign_ready); end
    @(posedge clk); #1;
    assign_valid = 1'b0;
    model_bt(0);
    run_bt(8'd0, 0, 0, acc, dc, da, sok);
    m = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i][17:1]) m++;
    total++;
    if (!acc || got_q.size() != 61 || exp_q.size() != 61 || m != 0) begin
      bad++; $display("FAIL drain_stream: got n=%0d mism=%0d want 61 0", got_q.size(), m);
    end
    total++;
    if (dc != 1 || da != 62 || trail_count !== 7'd3 || cur_level !== 8'd0 || bt_error !== 1'b0) begin
      bad++; $display("FAIL drain_after: got at=%0d cnt=%0d lvl=%0d err=%b want 62 3 0 0", da, trail_count, cur_level, bt_error);
    end
  endtask

  task automatic test_random();
    bit ok, acc, sok;
    int n, tgt, dc, da, m, fails;
    for (int it = 0; it < 15; it++) begin
      fails = 0;
      n = $urandom_range(0, 8);
      for (int k = 0; k < n && mq.size() < 64; k++) begin
        do_push(16'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), ok);
        if (!ok) fails++;
      end
      tgt = $urandom_range(0, mlevel() + 1);
      model_bt(tgt);
      run_bt(8'(tgt), $urandom_range(0, 2), 1, acc, dc, da, sok);
      m = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i][17:1]) m++;
      total++;
      if (fails != 0 || !acc || got_q.size() != exp_q.size() || m != 0) begin
        bad++; $display("FAIL rand_stream[%0d]: got n=%0d mism=%0d refused=%0d want %0d 0 0", it, got_q.size(), m, fails, exp_q.size());
      end
      total++;
      if (dc != 1 || cur_level !== 8'(mlevel()) || trail_count !== 7'(mq.size()) || bt_error !== 1'b0) begin
        bad++; $display("FAIL rand_after[%0d]: got pulses=%0d lvl=%0d cnt=%0d want 1 %0d %0d", it, dc, cur_level, trail_count, mlevel(), mq.size());
      end
    end
`ifdef TRAIL_STATS_EN
    total++;
    if (stat_bt_cnt !== 32'(mbt) || stat_undo_cnt !== 32'(mundo)) begin
      bad++; $display("FAIL rand_stats: got %0d %0d want %0d %0d", stat_bt_cnt, stat_undo_cnt, mbt, mundo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_push_bt();
    test_zero_pop();
    test_priority();
    test_stall();
    test_clear_mid_pop();
    test_full_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
